lwdf_synth2: RTL and testbench



---
 rtl/lwdf_synth2.sv | 193 +++++++++++++++++++
 tb/tb_lwdf_synth2.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lwdf_synth2.sv
// lwdf_synth2: two-channel lattice wave digital filter synthesis bank.
// One low-band and one high-band sample go in per handshake. The block
// recombines them through a polyphase allpass pair and produces two output
// samples: the even phase first, then the odd phase.
// A single 22x20 multiplier is shared across the three adaptors. Each
// adaptor gets the multiplier for one state: M0, M1 and then M2.
// Optional build macro: LWDF_SAT_EN. When it is defined, the datapath
// saturates instead of wrapping.

module lwdf_synth2 #(
  parameter logic signed [19:0] G0 = 20'sh04000,
  parameter logic signed [19:0] G1 = 20'sh02000,
  parameter logic signed [19:0] G2 = 20'sh06000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] lo_in,
  input  logic [31:0] hi_in,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] y_out,
  output logic        out_valid,
  input  logic        out_ready
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_BFLY = 3'd1;
  localparam logic [2:0] S_M0   = 3'd2;
  localparam logic [2:0] S_M1   = 3'd3;
  localparam logic [2:0] S_M2   = 3'd4;
  localparam logic [2:0] S_EVEN = 3'd5;
  localparam logic [2:0] S_ODD  = 3'd6;

  localparam logic signed [21:0] MAX22 = 22'sh1FFFFF;
  localparam logic signed [21:0] MIN22 = 22'sh200000;

  logic [2:0] state;

  logic signed [21:0] lo_r, hi_r;
  logic signed [21:0] u, v;
  logic signed [21:0] c0, c1, c2;
  logic signed [21:0] r0, t, r2;

  logic signed [19:0] mul_g;
  logic signed [21:0] mul_c, mul_x;
  logic signed [21:0] diff, p, c_next, r_next;
  logic signed [41:0] prod;
  logic signed [21:0] y_sel;

  // 22-bit add: wraps by default, clamps to the 7.15 range when saturation is built in
  function automatic logic signed [21:0] add22(input logic signed [21:0] a,
                                               input logic signed [21:0] b);
`ifdef LWDF_SAT_EN
    logic signed [22:0] s;
    s = a + b;
    if (s > 23'sh0FFFFF && s > 23'(MAX22))
      add22 = MAX22;
    else if (s < 23'(MIN22))
      add22 = MIN22;
    else
      add22 = 22'(s);
`else
    add22 = a + b;
`endif
  endfunction

  // 22-bit subtract, with the same overflow behaviour as add22
  function automatic logic signed [21:0] sub22(input logic signed [21:0] a,
                                               input logic signed [21:0] b);
`ifdef LWDF_SAT_EN
    logic signed [22:0] s;
    s = a - b;
    if (s > 23'(MAX22))
      sub22 = MAX22;
    else if (s < 23'(MIN22))
      sub22 = MIN22;
    else
      sub22 = 22'(s);
`else
    sub22 = a - b;
`endif
  endfunction

  // Shift the 42-bit product back to 7.15 (arithmetic shift by 15), then narrow it to 22 bits
  function automatic logic signed [21:0] trunc_prod(input logic signed [41:0] m);
`ifdef LWDF_SAT_EN
    logic signed [41:0] sh;
    sh = m >>> 15;
    if (sh > 42'(MAX22))
      trunc_prod = MAX22;
    else if (sh < 42'(MIN22))
      trunc_prod = MIN22;
    else
      trunc_prod = 22'(sh);
`else
    trunc_prod = 22'(m >>> 15);
`endif
  endfunction

  // Steer the gamma, stored state and adaptor input of the active adaptor into the shared multiplier
  always_comb begin
    mul_g = G0;
    mul_c = c0;
    mul_x = u;
    case (state)
      S_M1: begin
        mul_g = G1;
        mul_c = c1;
        mul_x = v;
      end
      S_M2: begin
        mul_g = G2;
        mul_c = c2;
        mul_x = t;
      end
      default: ;
    endcase
    diff   = sub22(mul_c, mul_x);
    prod   = 42'(mul_g) * 42'(diff);
    p      = trunc_prod(prod);
    c_next = add22(mul_x, p);
    r_next = add22(mul_c, p);
  end

  // Sequencer and datapath registers: one multiplier product per cycle in M0..M2
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      lo_r  <= '0;
      hi_r  <= '0;
      u     <= '0;
      v     <= '0;
      c0    <= '0;
      c1    <= '0;
      c2    <= '0;
      r0    <= '0;
      t     <= '0;
      r2    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            lo_r  <= 22'(lo_in >> 1);
            hi_r  <= 22'(hi_in >> 1);
            state <= S_BFLY;
          end
        end
        S_BFLY: begin
          u     <= add22(lo_r, hi_r);
          v     <= sub22(lo_r, hi_r);
          state <= S_M0;
        end
        S_M0: begin
          c0    <= c_next;
          r0    <= r_next;
          state <= S_M1;
        end
        S_M1: begin
          c1    <= c_next;
          t     <= r_next;
          state <= S_M2;
        end
        S_M2: begin
          c2    <= c_next;
          r2    <= r_next;
          state <= S_EVEN;
        end
        S_EVEN: begin
          if (out_ready)
            state <= S_ODD;
        end
        S_ODD: begin
          if (out_ready)
            state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Handshake flags and output select; y_out is zero whenever no sample is being offered
  always_comb begin
    in_ready  = (state == S_IDLE);
    out_valid = (state == S_EVEN) || (state == S_ODD);
    y_sel     = '0;
    if (state == S_EVEN)
      y_sel = r0;
    else if (state == S_ODD)
      y_sel = r2;
    y_out = {{9{y_sel[21]}}, y_sel, 1'b0};
  end

endmodule

// File: tb/tb_lwdf_synth2.sv
// tb_lwdf_synth2: self-checking bench for lwdf_synth2.
// dut_a is built with the default gammas. dut_b is built with all gammas set to
// zero, which makes it a pure delay line. Both DUTs share every input, so they
// run in lockstep.
// Expected outputs come from two sources: an arithmetic reference model, and a
// table of hand-derived vectors. When LWDF_SAT_EN is defined, the overflow
// expectations follow the saturating build.

module tb_lwdf_synth2;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] lo_in, hi_in;
  logic        in_valid, out_ready;
  logic        in_ready_a, in_ready_b;
  logic        out_valid_a, out_valid_b;
  logic [31:0] y_a, y_b;

  int checks   = 0;
  int failures = 0;

  int cyc_cnt = 0;
  int acc_cnt = 0;
  int ov_cnt  = 0;

  longint gam [2][3];
  longint mc  [2][3];

  typedef struct {
    logic [31:0] lo;
    logic [31:0] hi;
    logic [31:0] a_even;
    logic [31:0] a_odd;
    logic [31:0] b_even;
    logic [31:0] b_odd;
    bit          chk_a;
  } vec_t;

  vec_t vecs [5];

  always #5 clk = ~clk;

  lwdf_synth2 dut_a (
    .clk       (clk),
    .reset     (reset),
    .lo_in     (lo_in),
    .hi_in     (hi_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready_a),
    .y_out     (y_a),
    .out_valid (out_valid_a),
    .out_ready (out_ready)
  );

  lwdf_synth2 #(.G0(20'sh00000), .G1(20'sh00000), .G2(20'sh00000)) dut_b (
    .clk       (clk),
    .reset     (reset),
    .lo_in     (lo_in),
    .hi_in     (hi_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready_b),
    .y_out     (y_b),
    .out_valid (out_valid_b),
    .out_ready (out_ready)
  );

  // Count cycles, accepts and valid-output cycles for the throughput measurement
  always @(posedge clk) begin
    cyc_cnt <= cyc_cnt + 1;
    if (!reset && in_valid && in_ready_a)
      acc_cnt <= acc_cnt + 1;
    if (!reset && out_valid_a)
      ov_cnt <= ov_cnt + 1;
  end

  // Hard stop in case the sequence ever stalls
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic longint wrap22(input longint x);
    longint w;
    w = x & 64'h3FFFFF;
    if (w >= 64'sh200000)
      w = w - 64'sh400000;
    return w;
  endfunction

  function automatic longint fix22(input longint x);
`ifdef LWDF_SAT_EN
    if (x > 2097151)
      return 2097151;
    if (x < -2097152)
      return -2097152;
    return x;
`else
    return wrap22(x);
`endif
  endfunction

  task automatic adapt(input longint g, input longint c, input longint x,
                       output longint cn, output longint r);
    longint pp;
    pp = fix22((g * fix22(c - x)) >>> 15);
    cn = fix22(x + pp);
    r  = fix22(c + pp);
  endtask

  task automatic model_pair(input int k, input logic [31:0] lo, input logic [31:0] hi,
                            output logic [31:0] ev, output logic [31:0] od);
    longint l, h, uu, vv, rr0, tt, rr2, cn, tmp;
    l  = wrap22(longint'($signed(lo)) >>> 1);
    h  = wrap22(longint'($signed(hi)) >>> 1);
    uu = fix22(l + h);
    vv = fix22(l - h);
    adapt(gam[k][0], mc[k][0], uu, cn, rr0);
    mc[k][0] = cn;
    adapt(gam[k][1], mc[k][1], vv, cn, tt);
    mc[k][1] = cn;
    adapt(gam[k][2], mc[k][2], tt, cn, rr2);
    mc[k][2] = cn;
    tmp = rr0 * 2;
    ev  = tmp[31:0];
    tmp = rr2 * 2;
    od  = tmp[31:0];
  endtask

  task automatic clear_model();
    for (int k = 0; k < 2; k++)
      for (int j = 0; j < 3; j++)
        mc[k][j] = 0;
  endtask

  // Send one pair and collect both outputs, optionally stalling each output phase
  task automatic applyStimulus(input logic [31:0] lo, input logic [31:0] hi,
                               input int stall_e, input int stall_o,
                               output logic [31:0] ea, output logic [31:0] oa,
                               output logic [31:0] eb, output logic [31:0] ob);
    logic [31:0] ma_e, ma_o, mb_e, mb_o, hold_a, hold_b;
    int n;
    n = 0;
    while (!in_ready_a && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkOutput("in_ready_wait", 32'(in_ready_a), 32'd1);
    lo_in     = lo;
    hi_in     = hi;
    in_valid  = 1'b1;
    out_ready = (stall_e == 0);
    @(negedge clk);
    in_valid = 1'b0;
    lo_in    = $urandom;
    hi_in    = $urandom;
    n = 1;
    while (!out_valid_a && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput("latency", 32'(n), 32'd5);
    model_pair(0, lo, hi, ma_e, ma_o);
    model_pair(1, lo, hi, mb_e, mb_o);
    hold_a = y_a;
    hold_b = y_b;
    for (int i = 0; i < stall_e; i++) begin
      in_valid = (i == 0);
      @(negedge clk);
      in_valid = 1'b0;
      checkOutput("stall_even_y_a", y_a, hold_a);
      checkOutput("stall_even_y_b", y_b, hold_b);
      checkOutput("stall_even_flags", {30'd0, out_valid_a, in_ready_a}, 32'd2);
    end
    ea = y_a;
    eb = y_b;
    checkOutput("even_a_model", y_a, ma_e);
    checkOutput("even_b_model", y_b, mb_e);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = (stall_o == 0);
    checkOutput("odd_flags", {30'd0, out_valid_a, in_ready_a}, 32'd2);
    hold_a = y_a;
    for (int i = 0; i < stall_o; i++) begin
      in_valid = (i == 0);
      @(negedge clk);
      in_valid = 1'b0;
      checkOutput("stall_odd_y_a", y_a, hold_a);
      checkOutput("stall_odd_flags", {30'd0, out_valid_a, in_ready_a}, 32'd2);
    end
    oa = y_a;
    ob = y_b;
    checkOutput("odd_a_model", y_a, ma_o);
    checkOutput("odd_b_model", y_b, mb_o);
    out_ready = 1'b1;
    @(negedge clk);
    checkOutput("idle_after", {28'd0, out_valid_a, in_ready_a, out_valid_b, in_ready_b}, 32'h5);
  endtask

  initial begin
    logic [31:0] ea, oa, eb, ob;
    int c0, a0, o0;

    reset     = 1'b1;
    lo_in     = '0;
    hi_in     = '0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    gam[0][0] = 16384;
    gam[0][1] = 8192;
    gam[0][2] = 24576;
    gam[1][0] = 0;
    gam[1][1] = 0;
    gam[1][2] = 0;
    clear_model();

    vecs[0] = '{32'h00010000, 32'h0, 32'hFFFF8000, 32'h00003000, 32'h0, 32'h0, 1'b1};
    vecs[1] = '{32'h0, 32'h0, 32'h0000C000, 32'hFFFF3000, 32'h00010000, 32'h0, 1'b1};
    vecs[2] = '{32'h0, 32'h0, 32'h00006000, 32'h00002700, 32'h0, 32'h00010000, 1'b1};
    vecs[3] = '{32'h00280000, 32'h00280000, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0};
`ifdef LWDF_SAT_EN
    vecs[4] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h003FFFFE, 32'h0, 1'b0};
`else
    vecs[4] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'hFFD00000, 32'h0, 1'b0};
`endif

    repeat (3) @(negedge clk);
    checkOutput("reset_flags", {28'd0, out_valid_a, in_ready_a, out_valid_b, in_ready_b}, 32'h5);
    checkOutput("reset_y_a", y_a, 32'h0);
    reset = 1'b0;
    @(negedge clk);

    $display("[TB] table vectors");
    for (int i = 0; i < 5; i++) begin
      applyStimulus(vecs[i].lo, vecs[i].hi, 0, 0, ea, oa, eb, ob);
      if (vecs[i].chk_a) begin
        checkOutput($sformatf("vec%0d_even_a", i), ea, vecs[i].a_even);
        checkOutput($sformatf("vec%0d_odd_a", i), oa, vecs[i].a_odd);
      end
      checkOutput($sformatf("vec%0d_even_b", i), eb, vecs[i].b_even);
      checkOutput($sformatf("vec%0d_odd_b", i), ob, vecs[i].b_odd);
    end

    $display("[TB] backpressure");
    applyStimulus($urandom, $urandom, 10, 0, ea, oa, eb, ob);
    applyStimulus($urandom, $urandom, 2, 4, ea, oa, eb, ob);

    $display("[TB] throughput");
    c0 = cyc_cnt;
    a0 = acc_cnt;
    o0 = ov_cnt;
    for (int i = 0; i < 5; i++)
      applyStimulus($urandom, $urandom, 0, 0, ea, oa, eb, ob);
    checkOutput("thru_cycles", 32'(cyc_cnt - c0), 32'd35);
    checkOutput("thru_accepts", 32'(acc_cnt - a0), 32'd5);
    checkOutput("thru_valid_cycles", 32'(ov_cnt - o0), 32'd10);

    $display("[TB] random pairs");
    for (int i = 0; i < 25; i++)
      applyStimulus($urandom, $urandom, $urandom_range(0, 2), $urandom_range(0, 2),
                    ea, oa, eb, ob);

    $display("[TB] reset during M1");
    lo_in     = $urandom;
    hi_in     = $urandom;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("midreset_first_edge", {28'd0, out_valid_a, in_ready_a, out_valid_b, in_ready_b}, 32'h5);
    @(negedge clk);
    reset = 1'b0;
    checkOutput("midreset_flags", {28'd0, out_valid_a, in_ready_a, out_valid_b, in_ready_b}, 32'h5);
    checkOutput("midreset_y_a", y_a, 32'h0);
    checkOutput("midreset_y_b", y_b, 32'h0);
    clear_model();
    applyStimulus(32'h0, 32'h0, 0, 0, ea, oa, eb, ob);
    checkOutput("post_reset_even_a", ea, 32'h0);
    checkOutput("post_reset_odd_a", oa, 32'h0);
    checkOutput("post_reset_even_b", eb, 32'h0);
    checkOutput("post_reset_odd_b", ob, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
